// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit in front of Data_Memory. Takes one request
//   at a time, range/legality checks it, then drives the memory port.
//   Loads return sign/zero-extended data. Sub-doubleword stores do a
//   read-modify-write because the memory always writes 8 bytes at mem_addr.
//
// Ports
//   clk, reset             clock (rising edge), async active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_write              1 = store, 0 = load
//   req_funct3             RISC-V width/sign encoding
//   req_addr, req_wdata    byte address, right-justified store data
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_error   load result / error flag, qualified by rsp_valid
//   mem_write, mem_read    memory strobes (MemWrite/MemRead)
//   mem_size               memory SIZE
//   mem_addr, mem_wdata    memory address / write data
//   mem_rdata              memory read data (combinational in addr/size)
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q;
  // Holds store data (sd), merged doubleword (sb/sh/sw) or load result.
  logic [63:0] data_q;
  logic        err_q;

  logic [64:0] range_end;
  logic        out_of_range;
  logic        illegal;
  logic [63:0] load_ext;
  logic [63:0] merged;

  // 65-bit sum so an address near 2^64 cannot wrap into range.
  always_comb begin
    range_end    = {1'b0, req_addr} +
                   (req_write ? 65'd8 : (65'd1 << req_funct3[1:0]));
    out_of_range = range_end > 65'(MEM_BYTES);
    illegal      = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
  end

  always_comb begin
    load_ext = '0;
    case (f3_q)
      3'b000:  load_ext = {{56{mem_rdata[7]}},  mem_rdata[7:0]};
      3'b001:  load_ext = {{48{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b010:  load_ext = {{32{mem_rdata[31]}}, mem_rdata[31:0]};
      3'b011:  load_ext = mem_rdata;
      3'b100:  load_ext = {56'd0, mem_rdata[7:0]};
      3'b101:  load_ext = {48'd0, mem_rdata[15:0]};
      3'b110:  load_ext = {32'd0, mem_rdata[31:0]};
      default: load_ext = '0;
    endcase
  end

  // During a store's READ, data_q still holds the right-justified wdata.
  always_comb begin
    merged = mem_rdata;
    case (f3_q[1:0])
      2'b00:   merged = {mem_rdata[63:8],  data_q[7:0]};
      2'b01:   merged = {mem_rdata[63:16], data_q[15:0]};
      2'b10:   merged = {mem_rdata[63:32], data_q[31:0]};
      default: merged = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q   <= req_write;
            f3_q   <= req_funct3;
            addr_q <= req_addr;
            if (illegal || out_of_range) begin
              err_q   <= 1'b1;
              data_q  <= '0;
              state_q <= RESP;
            end else begin
              err_q   <= 1'b0;
              data_q  <= req_wdata;
              state_q <= (req_write && req_funct3[1:0] == 2'b11) ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (wr_q) begin
            data_q  <= merged;
            state_q <= WRITE;
          end else begin
            data_q  <= load_ext;
            state_q <= RESP;
          end
        end
        WRITE: begin
          data_q  <= '0;
          state_q <= RESP;
        end
        default: begin
          err_q   <= 1'b0;
          data_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state only; reset forcing IDLE
  // drops mem_write immediately so no write can commit.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_error = (state_q == RESP) && err_q;
    rsp_rdata = (state_q == RESP) ? data_q : '0;
    mem_read  = (state_q == READ);
    mem_write = (state_q == WRITE);
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == READ) begin
      mem_size = wr_q ? 2'b11 : f3_q[1:0];
      mem_addr = addr_q;
    end else if (state_q == WRITE) begin
      mem_size  = 2'b11;
      mem_addr  = addr_q;
      mem_wdata = data_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_write(mem_write), .mem_read(mem_read), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: 64 bytes, 8-byte write at the clock edge, combinational read.
  logic [7:0] dmem [64];
  // Reference contents, updated from request semantics only.
  logic [7:0] ref_mem [64];

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (mem_addr <= 64'(63 - i))
        mem_rdata[8*i +: 8] = dmem[mem_addr[5:0] + 6'(i)];
  end

  always @(posedge clk)
    if (mem_write)
      for (int i = 0; i < 8; i++)
        if (mem_addr <= 64'(63 - i))
          dmem[mem_addr[5:0] + 6'(i)] <= mem_wdata[8*i +: 8];

  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  logic [1:0]  last_rd_size = '0;
  always @(negedge clk) begin
    if (mem_read) begin
      rd_cnt++;
      last_rd_size = mem_size;
    end
    if (mem_write) wr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [63:0] last_rdata;

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d);
    int unsigned nb, lat, exp_lat, n, r0, w0;
    logic        exp_err, got;
    logic [63:0] exp_data;
    nb = 1 << f3[1:0];
    if (w) exp_err = f3[2] || (a > 64'd56);
    else   exp_err = (f3 == 3'b111) || (a > 64'(64 - nb));
    exp_data = '0;
    if (!exp_err && !w) begin
      for (int i = 0; i < int'(nb); i++)
        exp_data |= 64'(ref_mem[int'(a) + i]) << (8 * i);
      if (f3 < 3 && exp_data[8*nb-1])
        exp_data |= ~((64'd1 << (8 * nb)) - 1);
    end
    if (exp_err)                 exp_lat = 1;
    else if (!w || f3 == 3'b011) exp_lat = 2;
    else                         exp_lat = 3;

    @(negedge clk);
    check("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_busy", {63'd0, req_ready}, 64'd0);
    n = 1; got = 1'b0; lat = 0;
    while (n <= 6) begin
      if (rsp_valid) begin got = 1'b1; lat = n; break; end
      @(posedge clk); #1;
      n++;
    end
    check("rsp_seen", {63'd0, got}, 64'd1);
    if (got) begin
      check("rsp_latency", 64'(lat), 64'(exp_lat));
      check("rsp_error", {63'd0, rsp_error}, {63'd0, exp_err});
      check("rsp_rdata", rsp_rdata, exp_data);
      last_rdata = rsp_rdata;
    end
    check("reads", 64'(rd_cnt - r0), (!exp_err && !(w && f3 == 3'b011)) ? 64'd1 : 64'd0);
    check("writes", 64'(wr_cnt - w0), (!exp_err && w) ? 64'd1 : 64'd0);
    if (!exp_err && !(w && f3 == 3'b011))
      check("read_size", 64'(last_rd_size), w ? 64'd3 : 64'(f3[1:0]));
    @(posedge clk); #1;
    check("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
    check("ready_after", {63'd0, req_ready}, 64'd1);
    if (!exp_err && w)
      for (int i = 0; i < int'(nb); i++)
        ref_mem[int'(a) + i] = d[8*i +: 8];
  endtask

  initial begin
    int unsigned seen;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; last_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);

    do_req(1'b1, 3'b011, 64'd0, 64'h1122334455667788);
    do_req(1'b0, 3'b011, 64'd0, 64'd0);
    check("ld0_value", last_rdata, 64'h1122334455667788);
    do_req(1'b1, 3'b000, 64'd3, 64'h00000000000000AB);
    do_req(1'b0, 3'b011, 64'd0, 64'd0);
    check("ld0_after_sb", last_rdata, 64'h11223344AB667788);
    do_req(1'b0, 3'b000, 64'd3, 64'd0);
    check("lb3", last_rdata, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 3'b100, 64'd3, 64'd0);
    check("lbu3", last_rdata, 64'h00000000000000AB);
    do_req(1'b0, 3'b001, 64'd2, 64'd0);
    check("lh2", last_rdata, 64'hFFFFFFFFFFFFAB66);
    do_req(1'b0, 3'b110, 64'd0, 64'd0);
    check("lwu0", last_rdata, 64'h00000000AB667788);

    do_req(1'b0, 3'b011, 64'd57, 64'd0);
    do_req(1'b0, 3'b000, 64'd63, 64'd0);
    do_req(1'b1, 3'b000, 64'd56, 64'h5A);
    do_req(1'b1, 3'b000, 64'd57, 64'h5A);
    do_req(1'b1, 3'b000, 64'd60, 64'h5A);
    do_req(1'b0, 3'b011, 64'hFFFFFFFFFFFFFFFC, 64'd0);
    do_req(1'b0, 3'b111, 64'd0, 64'd0);
    do_req(1'b1, 3'b100, 64'd0, 64'hFFFF);
    do_req(1'b0, 3'b011, 64'd0, 64'd0);
    check("ld0_unchanged", last_rdata, 64'h11223344AB667788);

    // Reset during the WRITE cycle of sd @8.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'd8; req_wdata = 64'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("sd_in_write", {63'd0, mem_write}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_drops_write", {63'd0, mem_write}, 64'd0);
    check("rst_drops_addr", mem_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", 64'(seen), 64'd0);
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);
    do_req(1'b0, 3'b011, 64'd8, 64'd0);

    for (int k = 0; k < 60; k++) begin
      logic [63:0] a;
      a = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
      do_req(1'($urandom), 3'($urandom), a, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
